// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencing controller: validates key moves, owns the board,
// alternates turns, enforces a per-turn timeout and decides win/draw.
module ttt_game_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 32'd250_000_000,
  parameter int unsigned TW          = 32'd28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_en,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic [7:0]  win_line,
  output logic        move_err,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    PLACE    = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic          TIMER_ON   = (TIMEOUT_CYC != 32'd0);
  localparam logic [TW-1:0] TIMER_LAST = TIMER_ON ? TW'(TIMEOUT_CYC - 32'd1) : '0;

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    case (k)
      4'd1:    cell_of = b[17:16];
      4'd2:    cell_of = b[15:14];
      4'd3:    cell_of = b[13:12];
      4'd4:    cell_of = b[11:10];
      4'd5:    cell_of = b[9:8];
      4'd6:    cell_of = b[7:6];
      4'd7:    cell_of = b[5:4];
      4'd8:    cell_of = b[3:2];
      4'd9:    cell_of = b[1:0];
      default: cell_of = 2'b00;
    endcase
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] k,
                                           input logic [1:0] m);
    set_cell = b;
    case (k)
      4'd1:    set_cell[17:16] = m;
      4'd2:    set_cell[15:14] = m;
      4'd3:    set_cell[13:12] = m;
      4'd4:    set_cell[11:10] = m;
      4'd5:    set_cell[9:8]   = m;
      4'd6:    set_cell[7:6]   = m;
      4'd7:    set_cell[5:4]   = m;
      4'd8:    set_cell[3:2]   = m;
      4'd9:    set_cell[1:0]   = m;
      default: set_cell        = b;
    endcase
  endfunction

  // Bit order: rows 1-3, cols 1-3, diagonal 1-5-9, anti-diagonal 3-5-7.
  function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] m);
    logic [9:1] o;
    for (int i = 1; i <= 9; i++) o[i] = (cell_of(b, 4'(i)) == m);
    lines_of = {o[3] & o[5] & o[7], o[1] & o[5] & o[9],
                o[3] & o[6] & o[9], o[2] & o[5] & o[8], o[1] & o[4] & o[7],
                o[7] & o[8] & o[9], o[4] & o[5] & o[6], o[1] & o[2] & o[3]};
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic [9:1] f;
    for (int i = 1; i <= 9; i++) f[i] = (cell_of(b, 4'(i)) != 2'b00);
    board_full = &f;
  endfunction

  state_t        state_r;
  logic [3:0]    cell_r;
  logic [TW-1:0] timer_r;

  logic [1:0] mark_s;
  logic       digit_s;
  logic       move_ok_s;
  logic       move_bad_s;
  logic       expire_s;
  logic [7:0] lines_s;
  logic       full_s;

  assign mark_s     = turn_o ? 2'b10 : 2'b01;
  assign digit_s    = key_valid && (key_code >= 4'd1) && (key_code <= 4'd9);
  assign move_ok_s  = digit_s && (cell_of(board, key_code) == 2'b00);
  assign move_bad_s = digit_s && (cell_of(board, key_code) != 2'b00);
  assign expire_s   = TIMER_ON && (timer_r == TIMER_LAST);
  assign lines_s    = lines_of(board, mark_s);
  assign full_s     = board_full(board);

  // Game FSM with all outputs registered; play_en low overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cell_r   <= 4'd0;
      timer_r  <= '0;
      board    <= 18'd0;
      turn_o   <= 1'b0;
      result   <= 2'b00;
      win_line <= 8'd0;
      move_err <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      move_err <= 1'b0;
      timeout  <= 1'b0;
      if (!play_en) begin
        state_r  <= IDLE;
        timer_r  <= '0;
        board    <= 18'd0;
        turn_o   <= 1'b0;
        result   <= 2'b00;
        win_line <= 8'd0;
        busy     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= WAIT_KEY;
            timer_r <= '0;
            turn_o  <= 1'b0;
            busy    <= 1'b0;
          end
          WAIT_KEY: begin
            if (move_ok_s) begin
              cell_r  <= key_code;
              state_r <= PLACE;
              busy    <= 1'b1;
            end else begin
              move_err <= move_bad_s;
              if (expire_s) begin
                timeout <= 1'b1;
                turn_o  <= ~turn_o;
                timer_r <= '0;
              end else if (timer_r != TIMER_LAST) begin
                timer_r <= timer_r + TW'(1);
              end
            end
          end
          PLACE: begin
            board   <= set_cell(board, cell_r, mark_s);
            state_r <= CHECK;
            busy    <= 1'b1;
          end
          CHECK: begin
            busy <= 1'b0;
            if (lines_s != 8'd0) begin
              result   <= mark_s;
              win_line <= lines_s;
              state_r  <= DONE;
            end else if (full_s) begin
              result  <= 2'b11;
              state_r <= DONE;
            end else begin
              turn_o  <= ~turn_o;
              timer_r <= '0;
              state_r <= WAIT_KEY;
            end
          end
          DONE: begin
            if (key_valid && (key_code == 4'd0)) begin
              board    <= 18'd0;
              result   <= 2'b00;
              win_line <= 8'd0;
              turn_o   <= 1'b0;
              timer_r  <= '0;
              state_r  <= WAIT_KEY;
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
